// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter and future RX-side arbiters.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_DONE, RELEASE} state_t;

  localparam int MAX_BURST  = 4;
  localparam int MAX_DATA_W = 32;

  function automatic int frame_w(input int data_w);
    return data_w + 1;
  endfunction

  // Zero-extension of the data word leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module uart_rr_picker #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx,
  output logic            any
);

  always_comb begin
    int j;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        win_idx = PW'(j);
        win[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter; builds {parity, data} frames with a watchdog.
// Optional UART_TX_ARB_BURST_EN: up to MAX_BURST back-to-back frames per grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0,
  parameter int TIMEOUT    = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          grant,
  output logic                     tx_start,
  output logic [DATA_W:0]          tx_frame,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     tx_abort,
  output logic                     err_timeout
);

  localparam int FW = frame_w(DATA_W);
  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  state_t          state, state_d;
  logic [PW-1:0]   ptr, ptr_d, own, own_d, nxt_ptr;
  logic [WW-1:0]   wd, wd_d;
  logic [NREQ-1:0] grant_d, ack_d;
  logic            tx_start_d, tx_abort_d, err_d;
  logic [FW-1:0]   frame_d;

  logic [NREQ-1:0]   pick_win;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] pick_data;
  logic [FW-1:0]     pick_frame;

  uart_rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign pick_data  = req_data[pick_idx*DATA_W +: DATA_W];
  assign pick_frame = {calc_parity(MAX_DATA_W'(pick_data), PARITY_ODD != 0), pick_data};
  assign nxt_ptr    = (own == LAST_IDX) ? '0 : own + 1'b1;

`ifdef UART_TX_ARB_BURST_EN
  logic [2:0]        bcnt, bcnt_d;
  logic              bpend, bpend_d;
  logic [DATA_W-1:0] own_data;
  logic [FW-1:0]     own_frame;

  assign own_data  = req_data[own*DATA_W +: DATA_W];
  assign own_frame = {calc_parity(MAX_DATA_W'(own_data), PARITY_ODD != 0), own_data};
`endif

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    own_d      = own;
    wd_d       = wd;
    grant_d    = grant;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_abort_d = 1'b0;
    err_d      = err_timeout;
    frame_d    = tx_frame;
`ifdef UART_TX_ARB_BURST_EN
    bcnt_d     = bcnt;
    bpend_d    = bpend;
`endif
    case (state)
      IDLE: begin
        if (pick_any && !tx_busy) begin
          grant_d    = pick_win;
          own_d      = pick_idx;
          frame_d    = pick_frame;
          tx_start_d = 1'b1;
          wd_d       = '0;
          state_d    = WAIT_DONE;
`ifdef UART_TX_ARB_BURST_EN
          bcnt_d     = '0;
`endif
        end
      end
      WAIT_DONE: begin
        // tx_done takes priority over a watchdog expiry in the same cycle.
        if (tx_done) begin
          ack_d   = grant;
          state_d = RELEASE;
`ifdef UART_TX_ARB_BURST_EN
          if (req[own] && (int'(bcnt) < MAX_BURST - 1)) begin
            bpend_d = 1'b1;
            bcnt_d  = bcnt + 3'd1;
          end else begin
            ptr_d = nxt_ptr;
          end
`else
          ptr_d   = nxt_ptr;
`endif
        end else if (wd == WD_LAST) begin
          ack_d      = grant;
          tx_abort_d = 1'b1;
          err_d      = 1'b1;
          ptr_d      = nxt_ptr;
          state_d    = RELEASE;
`ifdef UART_TX_ARB_BURST_EN
          bpend_d    = 1'b0;
`endif
        end else begin
          wd_d = wd + 1'b1;
        end
      end
      RELEASE: begin
`ifdef UART_TX_ARB_BURST_EN
        // Requester refreshed req_data during the ack cycle; relaunch without dropping grant.
        if (bpend) begin
          frame_d    = own_frame;
          tx_start_d = 1'b1;
          wd_d       = '0;
          bpend_d    = 1'b0;
          state_d    = WAIT_DONE;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
`else
        grant_d = '0;
        state_d = IDLE;
`endif
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      own         <= '0;
      wd          <= '0;
      grant       <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_abort    <= 1'b0;
      err_timeout <= 1'b0;
      tx_frame    <= '0;
`ifdef UART_TX_ARB_BURST_EN
      bcnt        <= '0;
      bpend       <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      own         <= own_d;
      wd          <= wd_d;
      grant       <= grant_d;
      ack         <= ack_d;
      tx_start    <= tx_start_d;
      tx_abort    <= tx_abort_d;
      err_timeout <= err_d;
      tx_frame    <= frame_d;
`ifdef UART_TX_ARB_BURST_EN
      bcnt        <= bcnt_d;
      bpend       <= bpend_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: even- and odd-parity arbiters driven in lockstep, TIMEOUT=16.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic               tx_busy = 1'b0;
  logic               tx_done = 1'b0;

  logic [NREQ-1:0] ack, grant, ack_o, grant_o;
  logic            tx_start, tx_abort, err_timeout;
  logic            tx_start_o, tx_abort_o, err_o;
  logic [DW:0]     tx_frame, tx_frame_o;

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .PARITY_ODD(0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .grant(grant),
    .tx_start(tx_start), .tx_frame(tx_frame), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_abort(tx_abort), .err_timeout(err_timeout)
  );

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .PARITY_ODD(1), .TIMEOUT(TO)) dut_odd (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack_o), .grant(grant_o),
    .tx_start(tx_start_o), .tx_frame(tx_frame_o), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_abort(tx_abort_o), .err_timeout(err_o)
  );

  typedef struct { logic [NREQ-1:0] g; logic [DW:0] fe; logic [DW:0] fo; } launch_t;
  typedef struct { logic [NREQ-1:0] a; logic ab; } ackx_t;
  launch_t lq[$];
  ackx_t   aq[$];

  int n_tot  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // Monitor: pops expectations whenever a launch or an ack appears.
  launch_t ml;
  ackx_t   ma;
  always @(negedge clk) begin
    if (rst) begin
      if (tx_start) begin
        if (lq.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else begin
          ml = lq.pop_front();
          chk("launch_grant", 32'(grant), 32'(ml.g));
          chk("launch_frame_even", 32'(tx_frame), 32'(ml.fe));
          chk("launch_frame_odd", 32'(tx_frame_o), 32'(ml.fo));
          chk("launch_grant_odd", 32'(grant_o), 32'(ml.g));
          chk("launch_start_odd", 32'(tx_start_o), 32'd1);
        end
      end
      if (ack != '0) begin
        if (aq.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
        else begin
          ma = aq.pop_front();
          chk("ack_vec", 32'(ack), 32'(ma.a));
          chk("ack_abort", 32'(tx_abort), 32'(ma.ab));
          chk("ack_vec_odd", 32'(ack_o), 32'(ma.a));
          chk("ack_abort_odd", 32'(tx_abort_o), 32'(ma.ab));
        end
      end
    end
  end

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [DW:0] fe, input logic [DW:0] fo,
                      input logic ab);
    launch_t l;
    ackx_t   a;
    l.g = g; l.fe = fe; l.fo = fo;
    a.a = g; a.ab = ab;
    lq.push_back(l);
    aq.push_back(a);
  endtask

  task automatic wait_start(input string nm, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_start && n < 40);
    if (!tx_start) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic wait_ack(input string nm, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (ack == '0 && n < 40);
    if (ack == '0) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
  endtask

  int n;
  logic [DW:0] fair_fe [4] = '{9'h03C, 9'h107, 9'h0FF, 9'h180};
  logic [DW:0] fair_fo [4] = '{9'h13C, 9'h007, 9'h1FF, 9'h080};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ctl", {29'd0, tx_start, tx_abort, err_timeout}, 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_frame", 32'(tx_frame), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Single request, held off by tx_busy first
    tx_busy = 1'b1;
    set_data(1, 8'hA5);
    req = 4'b0010;
    push(4'b0010, 9'h0A5, 9'h1A5, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_hold", 32'(grant), 32'd0);
    tx_busy = 1'b0;
    wait_start("single_start_to", n);
    chk("start_latency", 32'(n), 32'd1);
    repeat (4) @(posedge clk);
    pulse_done();
    wait_ack("single_ack_to", n);
    chk("ack_latency", 32'(n), 32'd1);
    chk("grant_during_ack", 32'(grant), 32'b0010);
    req = '0;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("grant_released", 32'(grant), 32'd0);

    // Parity: single set bit, requester 0 (pointer now at 2, wraps to 0)
    set_data(0, 8'h01);
    req = 4'b0001;
    push(4'b0001, 9'h101, 9'h001, 1'b0);
    wait_start("parity_start_to", n);
    repeat (2) @(posedge clk);
    pulse_done();
    wait_ack("parity_ack_to", n);
    req = '0;

    // Collision: tx_done exactly on the expiry edge
    set_data(3, 8'hC3);
    req = 4'b1000;
    push(4'b1000, 9'h0C3, 9'h1C3, 1'b0);
    wait_start("coll_start_to", n);
    repeat (14) @(posedge clk);
    pulse_done();
    wait_ack("coll_ack_to", n);
    req = '0;
    @(negedge clk);
    chk("coll_no_err", 32'(err_timeout), 32'd0);
    chk("coll_no_err_odd", 32'(err_o), 32'd0);

    // Timeout: tx_done never arrives
    set_data(2, 8'h5A);
    req = 4'b0100;
    push(4'b0100, 9'h05A, 9'h15A, 1'b1);
    wait_start("to_start_to", n);
    wait_ack("to_ack_to", n);
    chk("abort_latency", 32'(n), 32'd16);
    req = '0;
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(err_timeout), 32'd1);
    chk("err_sticky_odd", 32'(err_o), 32'd1);
    chk("to_grant_released", 32'(grant), 32'd0);

    // Reset mid-frame
    set_data(1, 8'hA5);
    req = 4'b0010;
    push(4'b0010, 9'h0A5, 9'h1A5, 1'b0);
    void'(aq.pop_back());
    wait_start("rstmid_start_to", n);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_ctl", {29'd0, tx_start, tx_abort, err_timeout}, 32'd0);
    chk("rstmid_ack", 32'(ack), 32'd0);
    chk("rstmid_err_odd", 32'(err_o), 32'd0);

    // Fairness with all requests held; pointer restarts at 0
    set_data(0, 8'h3C); set_data(1, 8'h07); set_data(2, 8'hFF); set_data(3, 8'h80);
    req = 4'b1111;
    @(posedge clk); #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(4'b0001 << (i % 4), fair_fe[i % 4], fair_fo[i % 4], 1'b0);
      wait_start("fair_start_to", n);
      repeat (8) @(posedge clk);
      pulse_done();
      wait_ack("fair_ack_to", n);
      if (i == 4) req = '0;
    end

    repeat (4) @(negedge clk);
    chk("launch_queue_empty", 32'(lq.size()), 32'd0);
    chk("ack_queue_empty", 32'(aq.size()), 32'd0);
    chk("final_idle_grant", 32'(grant), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
